l2_cache_nway: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate L2 cache. It sits between the L1 caches (256-bit line port) and the cacheline adapter (256-bit pmem port). It is the successor to the fixed 2-way L2:
- way count and set count are parameters;
- replacement is tree pseudo-LRU;
- line writes honour a per-byte mask.

---
 rtl/l2_nway_types.sv | 57 +++++
 rtl/l2_plru_tree.sv | 34 +++
 rtl/l2_cache_nway.sv | 164 ++++++++++++++++
 tb/tb_l2_cache_nway.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/l2_nway_types.sv
// Shared types and tree pseudo-LRU helpers for the N-way L2 cache.
// The PLRU helpers work on a fixed maximum-width vector; callers pass the real tree depth.
package l2_nway_types;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } l2_state_e;

  localparam int max_way_bits = 5;
  localparam int max_nodes    = (1 << max_way_bits) - 1;

  // Walk from the root following each node bit (0 = left) to the victim leaf.
  function automatic logic [max_way_bits-1:0] plru_victim(
    input logic [max_nodes-1:0] bits,
    input int                   levels
  );
    logic [max_way_bits-1:0] node;
    logic [max_way_bits-1:0] way;
    node = '0;
    way  = '0;
    for (int l = 0; l < max_way_bits; l++) begin
      if (l < levels) begin
        way  = {way[max_way_bits-2:0], bits[node]};
        node = {node[max_way_bits-2:0], 1'b0} + max_way_bits'(1)
             + {{(max_way_bits-1){1'b0}}, bits[node]};
      end
    end
    return way;
  endfunction

  // Every node on the accessed way's path is pointed at the opposite subtree.
  function automatic logic [max_nodes-1:0] plru_update(
    input logic [max_nodes-1:0]    bits,
    input logic [max_way_bits-1:0] way,
    input int                      levels
  );
    logic [max_nodes-1:0]    upd;
    logic [max_way_bits-1:0] node;
    logic [max_way_bits-1:0] path;
    logic                    dir;
    upd  = bits;
    node = '0;
    for (int l = 0; l < max_way_bits; l++) begin
      if (l < levels) begin
        path      = way >> (levels - 1 - l);
        dir       = path[0];
        upd[node] = ~dir;
        node      = {node[max_way_bits-2:0], 1'b0} + max_way_bits'(1)
                  + {{(max_way_bits-1){1'b0}}, dir};
      end
    end
    return upd;
  endfunction

endpackage

// File: rtl/l2_plru_tree.sv
// Combinational tree-PLRU: victim selection and post-access bit update for one set.
module l2_plru_tree
  import l2_nway_types::*;
#(
  parameter int s_way = 2
) (
  input  logic [2**s_way-2:0] bits,
  input  logic [s_way-1:0]    access_way,
  output logic [s_way-1:0]    victim,
  output logic [2**s_way-2:0] updated
);

  localparam int num_nodes = 2 ** s_way - 1;

  logic [max_nodes-1:0]    bits_ext;
  logic [max_nodes-1:0]    upd_ext;
  logic [max_way_bits-1:0] acc_ext;
  logic [max_way_bits-1:0] vic_ext;
  logic                    unused_ext;

  always_comb begin
    bits_ext                  = '0;
    bits_ext[num_nodes-1:0]   = bits;
    acc_ext                   = '0;
    acc_ext[s_way-1:0]        = access_way;
    vic_ext                   = plru_victim(bits_ext, s_way);
    upd_ext                   = plru_update(bits_ext, acc_ext, s_way);
  end

  assign victim     = vic_ext[s_way-1:0];
  assign updated    = upd_ext[num_nodes-1:0];
  assign unused_ext = ^{upd_ext, vic_ext};

endmodule

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back, write-allocate L2 with tree-PLRU and byte-masked writes.
// Handshake: L1 holds mem_read/mem_write until a one-cycle mem_resp; pmem_read/pmem_write are held until pmem_resp.
module l2_cache_nway
  import l2_nway_types::*;
#(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_way    = 2,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [2**s_offset-1:0]      mem_byte_enable,
  input  logic [31:0]                 mem_address,
  input  logic [8*(2**s_offset)-1:0]  mem_wdata,
  output logic                        mem_resp,
  output logic [8*(2**s_offset)-1:0]  mem_rdata,
  input  logic                        pmem_resp,
  input  logic [8*(2**s_offset)-1:0]  pmem_rdata,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [31:0]                 pmem_address,
  output logic [8*(2**s_offset)-1:0]  pmem_wdata,
  output logic [1:0]                  dbg_state
);

  localparam int line_bytes = 2 ** s_offset;
  localparam int line_bits  = 8 * line_bytes;
  localparam int num_sets   = 2 ** s_index;
  localparam int num_ways   = 2 ** s_way;
  localparam int num_nodes  = num_ways - 1;

  l2_state_e state, state_next;

  logic [s_tag-1:0]     tag_arr   [num_sets][num_ways];
  logic [line_bits-1:0] data_arr  [num_sets][num_ways];
  logic [num_ways-1:0]  valid_arr [num_sets];
  logic [num_ways-1:0]  dirty_arr [num_sets];
  logic [num_nodes-1:0] plru_arr  [num_sets];

  logic [s_tag-1:0]     req_tag;
  logic [s_index-1:0]   req_idx;
  logic                 req;
  logic                 hit;
  logic                 has_inv;
  logic                 victim_dirty;
  logic [s_way-1:0]     hit_way;
  logic [s_way-1:0]     inv_way;
  logic [s_way-1:0]     plru_way;
  logic [s_way-1:0]     victim_sel;
  logic [s_way-1:0]     victim_q;
  logic [num_nodes-1:0] plru_next;
  logic [line_bits-1:0] hit_line;
  logic [line_bits-1:0] merged_line;
  logic                 unused_offset;

  assign req_tag       = mem_address[31 -: s_tag];
  assign req_idx       = mem_address[s_offset +: s_index];
  assign req           = mem_read | mem_write;
  assign unused_offset = ^mem_address[s_offset-1:0];
  assign dbg_state     = state;

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (valid_arr[req_idx][w] && (tag_arr[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = s_way'(w);
      end
      if (!valid_arr[req_idx][w]) begin
        has_inv = 1'b1;
        inv_way = s_way'(w);
      end
    end
  end

  l2_plru_tree #(.s_way(s_way)) u_plru (
    .bits       (plru_arr[req_idx]),
    .access_way (hit_way),
    .victim     (plru_way),
    .updated    (plru_next)
  );

  assign victim_sel   = has_inv ? inv_way : plru_way;
  assign victim_dirty = valid_arr[req_idx][victim_sel] && dirty_arr[req_idx][victim_sel];
  assign hit_line     = data_arr[req_idx][hit_way];
  assign mem_rdata    = hit_line;
  assign pmem_wdata   = data_arr[req_idx][victim_q];

  always_comb begin
    merged_line = hit_line;
    for (int b = 0; b < line_bytes; b++) begin
      if (mem_byte_enable[b]) merged_line[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    case (state)
      CHECK: begin
        if (req) begin
          if (hit) mem_resp = 1'b1;
          else     state_next = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[req_idx][victim_q], req_idx, {s_offset{1'b0}}};
        if (pmem_resp) state_next = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_idx, {s_offset{1'b0}}};
        if (pmem_resp) state_next = CHECK;
      end
      default: state_next = CHECK;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CHECK;
      victim_q <= '0;
      for (int s = 0; s < num_sets; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
    end else begin
      state <= state_next;
      if ((state == CHECK) && (state_next != CHECK)) victim_q <= victim_sel;
      // A write completes as a hit, so a write miss gets its dirty bit after the refill.
      if (mem_resp) begin
        plru_arr[req_idx] <= plru_next;
        if (mem_write) dirty_arr[req_idx][hit_way] <= 1'b1;
      end
      if ((state == WRITEBACK) && pmem_resp) dirty_arr[req_idx][victim_q] <= 1'b0;
      if ((state == FILL) && pmem_resp) begin
        valid_arr[req_idx][victim_q] <= 1'b1;
        dirty_arr[req_idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tags and data carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (mem_resp && mem_write) data_arr[req_idx][hit_way] <= merged_line;
    if ((state == FILL) && pmem_resp) begin
      data_arr[req_idx][victim_q] <= pmem_rdata;
      tag_arr[req_idx][victim_q]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed bench for l2_cache_nway: a 4-way/8-set build and a 2-way/2-set build share one stimulus path.
module tb_l2_cache_nway;
  import l2_nway_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, use_b;
  logic         mem_read, mem_write, pmem_resp;
  logic [31:0]  mem_byte_enable, mem_address;
  logic [255:0] mem_wdata, pmem_rdata;

  logic         a_mem_resp, a_pmem_read, a_pmem_write, b_mem_resp, b_pmem_read, b_pmem_write;
  logic [255:0] a_mem_rdata, a_pmem_wdata, b_mem_rdata, b_pmem_wdata;
  logic [31:0]  a_pmem_address, b_pmem_address;
  logic [1:0]   a_dbg_state, b_dbg_state;

  wire          a_rd = mem_read & ~use_b, a_wr = mem_write & ~use_b, a_pr = pmem_resp & ~use_b;
  wire          b_rd = mem_read & use_b,  b_wr = mem_write & use_b,  b_pr = pmem_resp & use_b;

  wire          resp   = use_b ? b_mem_resp     : a_mem_resp;
  wire [255:0]  rdata  = use_b ? b_mem_rdata    : a_mem_rdata;
  wire          p_rd   = use_b ? b_pmem_read    : a_pmem_read;
  wire          p_wr   = use_b ? b_pmem_write   : a_pmem_write;
  wire [31:0]   p_addr = use_b ? b_pmem_address : a_pmem_address;
  wire [255:0]  p_wd   = use_b ? b_pmem_wdata   : a_pmem_wdata;
  wire [1:0]    dstate = use_b ? b_dbg_state    : a_dbg_state;

  l2_cache_nway dut_a (
    .clk(clk), .rst(rst), .mem_read(a_rd), .mem_write(a_wr),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(a_mem_resp), .mem_rdata(a_mem_rdata), .pmem_resp(a_pr), .pmem_rdata(pmem_rdata),
    .pmem_read(a_pmem_read), .pmem_write(a_pmem_write), .pmem_address(a_pmem_address),
    .pmem_wdata(a_pmem_wdata), .dbg_state(a_dbg_state)
  );

  l2_cache_nway #(.s_way(1), .s_index(1)) dut_b (
    .clk(clk), .rst(rst), .mem_read(b_rd), .mem_write(b_wr),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(b_mem_resp), .mem_rdata(b_mem_rdata), .pmem_resp(b_pr), .pmem_rdata(pmem_rdata),
    .pmem_read(b_pmem_read), .pmem_write(b_pmem_write), .pmem_address(b_pmem_address),
    .pmem_wdata(b_pmem_wdata), .dbg_state(b_dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int k);
    return {8{32'hC0DE_0000 | 32'(k)}};
  endfunction

  // Request that must complete in the same cycle it is presented.
  task automatic hit(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] be, input logic [255:0] wd, input logic [255:0] exp_rd);
    mem_read = rd; mem_write = wr; mem_address = addr; mem_byte_enable = be; mem_wdata = wd;
    #1;
    chk({tag, "_resp"}, resp, 1'b1);
    chk({tag, "_no_pmem"}, {p_rd, p_wr}, 2'b00);
    if (!wr) chk({tag, "_rdata"}, rdata, exp_rd);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0;
  endtask

  // Read miss, optionally preceded by a dirty-victim writeback, completing with fill_line.
  task automatic miss(input string tag, input logic [31:0] addr, input logic wb,
                      input logic [31:0] wb_addr, input logic [255:0] wb_line,
                      input logic [255:0] fill_line);
    mem_read = 1'b1; mem_write = 1'b0; mem_address = addr;
    #1;
    chk({tag, "_no_resp"}, resp, 1'b0);
    @(posedge clk); #1;
    if (wb) begin
      chk({tag, "_wb_state"}, dstate, WRITEBACK);
      chk({tag, "_wb_req"}, {p_wr, p_rd}, 2'b10);
      chk({tag, "_wb_addr"}, p_addr, wb_addr);
      chk({tag, "_wb_data"}, p_wd, wb_line);
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_wb_hold"}, {p_wr, p_rd}, 2'b10);
      pmem_resp = 1'b1;
      @(posedge clk); #1;
      pmem_resp = 1'b0;
    end
    chk({tag, "_fill_state"}, dstate, FILL);
    chk({tag, "_fill_req"}, {p_wr, p_rd}, 2'b01);
    chk({tag, "_fill_addr"}, p_addr, addr);
    @(posedge clk); #1;
    pmem_rdata = fill_line; pmem_resp = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    #1;
    chk({tag, "_fill_drop"}, {p_wr, p_rd}, 2'b00);
    chk({tag, "_resp"}, resp, 1'b1);
    chk({tag, "_rdata"}, rdata, fill_line);
    @(posedge clk); #1;
    mem_read = 1'b0;
  endtask

  logic [255:0] l0, l0_mod, wd_aa, l11, l11_mod, wd_5a;

  initial begin
    rst = 1'b0; use_b = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    mem_byte_enable = '0; mem_address = '0; mem_wdata = '0; pmem_rdata = '0;
    l0      = pat(0);
    wd_aa   = {{28{8'h55}}, {4{8'hAA}}};
    l0_mod  = {l0[255:32], 32'hAAAA_AAAA};
    l11     = pat(11);
    wd_5a   = {32{8'h5A}};
    l11_mod = {32'h5A5A_5A5A, l11[223:0]};

    #1;
    chk("reset_state", dstate, CHECK);
    chk("reset_pmem", {p_wr, p_rd}, 2'b00);
    chk("reset_addr", p_addr, 32'h0);
    chk("reset_resp", resp, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // 4-way build, everything in set 2.
    miss("cold_40", 32'h0000_0040, 1'b0, 32'h0, '0, l0);
    hit("wr_40", 1'b0, 1'b1, 32'h0000_0040, 32'h0000_000F, wd_aa, '0);
    hit("rd_40", 1'b1, 1'b0, 32'h0000_0040, '0, '0, l0_mod);
    miss("fill_140", 32'h0000_0140, 1'b0, 32'h0, '0, pat(1));
    miss("fill_240", 32'h0000_0240, 1'b0, 32'h0, '0, pat(2));
    miss("fill_340", 32'h0000_0340, 1'b0, 32'h0, '0, pat(3));
    hit("hit_w0", 1'b1, 1'b0, 32'h0000_0040, '0, '0, l0_mod);
    hit("hit_w1", 1'b1, 1'b0, 32'h0000_0140, '0, '0, pat(1));
    hit("hit_w2", 1'b1, 1'b0, 32'h0000_0240, '0, '0, pat(2));
    // Tree bits after hits 0,1,2 are root=0, node1=0: victim is way 0, which holds the dirty line.
    miss("evict_w0", 32'h0000_0440, 1'b1, 32'h0000_0040, l0_mod, pat(4));
    hit("keep_w1", 1'b1, 1'b0, 32'h0000_0140, '0, '0, pat(1));
    // Now root=1, node2=1: victim is way 3 (clean 0x340), so no writeback.
    miss("evict_w3", 32'h0000_0040, 1'b0, 32'h0, '0, pat(5));

    // Asynchronous reset in the middle of a fill.
    mem_read = 1'b1; mem_address = 32'h0000_0540;
    @(posedge clk); #1;
    chk("rst_pre_fill", {p_wr, p_rd}, 2'b01);
    #3 rst = 1'b0;
    #1;
    chk("rst_pmem_drop", {p_wr, p_rd}, 2'b00);
    chk("rst_addr_zero", p_addr, 32'h0);
    chk("rst_state", dstate, CHECK);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    miss("rst_same", 32'h0000_0540, 1'b0, 32'h0, '0, pat(6));
    miss("rst_lost_140", 32'h0000_0140, 1'b0, 32'h0, '0, pat(7));
    hit("rst_hit_540", 1'b1, 1'b0, 32'h0000_0540, '0, '0, pat(6));

    // 2-way, 2-set build: set 0 addresses 0x000, 0x040, 0x080.
    use_b = 1'b1;
    #1;
    miss("b_cold_000", 32'h0000_0000, 1'b0, 32'h0, '0, pat(10));
    miss("b_cold_040", 32'h0000_0040, 1'b0, 32'h0, '0, l11);
    hit("b_hit_000", 1'b1, 1'b0, 32'h0000_0000, '0, '0, pat(10));
    hit("b_wr_040", 1'b1, 1'b1, 32'h0000_0040, 32'hF000_0000, wd_5a, '0);
    hit("b_rd_040", 1'b1, 1'b0, 32'h0000_0040, '0, '0, l11_mod);
    hit("b_hit_000b", 1'b1, 1'b0, 32'h0000_0000, '0, '0, pat(10));
    miss("b_evict_040", 32'h0000_0080, 1'b1, 32'h0000_0040, l11_mod, pat(12));
    hit("b_keep_000", 1'b1, 1'b0, 32'h0000_0000, '0, '0, pat(10));
    miss("b_refetch_040", 32'h0000_0040, 1'b0, 32'h0, '0, pat(13));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
